ref_clk_train_ctrl: RTL and testbench

Training sequencer for the DDR4 reference-clock receive lane. It sits directly downstream of the reference-clock training IOD. It consumes that lane's 8-bit deserialized word and its eye-monitor flags, and drives the lane's dynamic delay-line controls back upstream. It sweeps the input delay to find the first reference-clock edge, backs off a fixed number of taps, and reports the final tap position to the DDR PHY training logic.

---
 rtl/ref_clk_train_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_ref_clk_train_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_clk_train_ctrl.sv
// Reference-clock lane training sequencer: sweeps the IOD delay line to the first clock edge, then backs off.
// Define REF_CLK_TRAIN_EYE_MON_EN to let the eye-monitor EARLY/LATE flags disqualify a sample window.
module ref_clk_train_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_WORDS  = 8,
    parameter int MAX_TAPS      = 127,
    parameter int BACKOFF_TAPS  = 4
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       TRAIN_START,
    input  logic [7:0] RX_DATA,
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       TRAIN_BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR,
    output logic [7:0] TAP_COUNT,
    output logic [7:0] EDGE_TAP
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CLEAR,
        S_SAMPLE,
        S_EVAL,
        S_STEP,
        S_BACK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_WORDS - 1);
    localparam logic [7:0] MAX_TAP_L   = 8'(MAX_TAPS);
    localparam logic [7:0] BACKOFF_L   = 8'(BACKOFF_TAPS);

    state_t     state, state_next;
    logic [7:0] settle_cnt;
    logic [7:0] sample_cnt;
    logic [7:0] win_pat;
    logic       win_bad;
    logic [7:0] ref_pat;
    logic       ref_valid;
    logic [7:0] tap_count;
    logic [7:0] edge_tap;
    logic [7:0] back_cnt;
    logic       backing;
    logic       done_q;
    logic       err_q;
    logic       dir_q;
    logic       dir_next;
    logic       load_pulse;
    logic       move_pulse;
    logic       clear_pulse;
    logic       eval_latch;
    logic       eval_edge;
    logic       eye_hit;
    logic       start_req;

`ifdef REF_CLK_TRAIN_EYE_MON_EN
    assign eye_hit                 = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
    assign EYE_MONITOR_CLEAR_FLAGS = clear_pulse;
`else
    logic unused_eye;
    assign unused_eye              = &{1'b0, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, clear_pulse};
    assign eye_hit                 = 1'b0;
    assign EYE_MONITOR_CLEAR_FLAGS = 1'b0;
`endif

    assign start_req = TRAIN_START &&
                       (state == S_IDLE || state == S_DONE || state == S_ERR);

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode; datapath side effects key off these flags.
    always_comb begin
        state_next  = state;
        load_pulse  = 1'b0;
        move_pulse  = 1'b0;
        clear_pulse = 1'b0;
        dir_next    = dir_q;
        eval_latch  = 1'b0;
        eval_edge   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (TRAIN_START) state_next = S_LOAD;
            end
            S_LOAD: begin
                load_pulse = 1'b1;
                state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_next = backing ? S_BACK : S_CLEAR;
            end
            S_CLEAR: begin
                clear_pulse = 1'b1;
                state_next  = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (sample_cnt == SAMPLE_LAST) state_next = S_EVAL;
            end
            S_EVAL: begin
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    state_next = S_ERR;
                end else if (!ref_valid) begin
                    eval_latch = !win_bad;
                    state_next = S_STEP;
                end else if (win_bad || (win_pat != ref_pat)) begin
                    eval_edge  = 1'b1;
                    state_next = (BACKOFF_TAPS == 0 || tap_count == 8'd0) ? S_DONE : S_BACK;
                end else begin
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                if (tap_count == MAX_TAP_L) begin
                    state_next = S_ERR;
                end else begin
                    move_pulse = 1'b1;
                    dir_next   = 1'b1;
                    state_next = S_SETTLE;
                end
            end
            S_BACK: begin
                if (tap_count == 8'd0) begin
                    state_next = S_DONE;
                end else begin
                    move_pulse = 1'b1;
                    dir_next   = 1'b0;
                    if ((back_cnt + 8'd1) == BACKOFF_L || tap_count == 8'd1) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_SETTLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counters, window capture and the tap bookkeeping reported upstream.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            win_pat    <= '0;
            win_bad    <= 1'b0;
            ref_pat    <= '0;
            ref_valid  <= 1'b0;
            tap_count  <= '0;
            edge_tap   <= '0;
            back_cnt   <= '0;
            backing    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            dir_q <= dir_next;
            if (start_req) begin
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                tap_count <= '0;
                edge_tap  <= '0;
                ref_valid <= 1'b0;
                backing   <= 1'b0;
                back_cnt  <= '0;
            end
            if (state_next == S_DONE && state != S_DONE) done_q <= 1'b1;
            if (state_next == S_ERR && state != S_ERR)   err_q  <= 1'b1;

            case (state)
                S_LOAD:   settle_cnt <= '0;
                S_SETTLE: settle_cnt <= settle_cnt + 8'd1;
                S_CLEAR:  sample_cnt <= '0;
                S_SAMPLE: begin
                    sample_cnt <= sample_cnt + 8'd1;
                    if (sample_cnt == 8'd0) begin
                        win_pat <= RX_DATA;
                        win_bad <= !(RX_DATA == 8'h55 || RX_DATA == 8'hAA) || eye_hit;
                    end else begin
                        win_bad <= win_bad || (RX_DATA != win_pat) || eye_hit;
                    end
                end
                S_EVAL: begin
                    if (eval_latch) begin
                        ref_pat   <= win_pat;
                        ref_valid <= 1'b1;
                    end
                    if (eval_edge) edge_tap <= tap_count;
                    if (state_next == S_BACK) begin
                        backing  <= 1'b1;
                        back_cnt <= '0;
                    end
                end
                S_STEP: begin
                    if (move_pulse) tap_count <= tap_count + 8'd1;
                    settle_cnt <= '0;
                end
                S_BACK: begin
                    if (move_pulse) begin
                        tap_count <= tap_count - 8'd1;
                        back_cnt  <= back_cnt + 8'd1;
                    end
                    settle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign DELAY_LINE_LOAD      = load_pulse;
    assign DELAY_LINE_MOVE      = move_pulse;
    assign DELAY_LINE_DIRECTION = dir_next;
    assign TRAIN_BUSY           = !(state == S_IDLE || state == S_DONE || state == S_ERR);
    assign TRAIN_DONE           = done_q;
    assign TRAIN_ERR            = err_q;
    assign TAP_COUNT            = tap_count;
    assign EDGE_TAP             = edge_tap;

endmodule

// File: tb/tb_ref_clk_train_ctrl.sv
// Scoreboard bench for ref_clk_train_ctrl: a delay-line model feeds RX_DATA, a monitor checks LOAD/MOVE/DONE/ERR events.
// Honours REF_CLK_TRAIN_EYE_MON_EN for the eye-monitor scenario and the CLEAR pulse count.
module tb_ref_clk_train_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N = 1'b1;
    logic       TRAIN_START = 1'b0;
    logic [7:0] RX_DATA = 8'h55;
    logic       EYE_MONITOR_EARLY = 1'b0;
    logic       EYE_MONITOR_LATE = 1'b0;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic       TRAIN_BUSY;
    logic       TRAIN_DONE;
    logic       TRAIN_ERR;
    logic [7:0] TAP_COUNT;
    logic [7:0] EDGE_TAP;

    ref_clk_train_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST_N                  (ARST_N),
        .TRAIN_START             (TRAIN_START),
        .RX_DATA                 (RX_DATA),
        .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
        .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .TRAIN_BUSY              (TRAIN_BUSY),
        .TRAIN_DONE              (TRAIN_DONE),
        .TRAIN_ERR               (TRAIN_ERR),
        .TAP_COUNT               (TAP_COUNT),
        .EDGE_TAP                (EDGE_TAP)
    );

    typedef struct {
        int         kind;      // 0 LOAD, 1 MOVE, 2 DONE/ERR rise
        logic       dir;
        logic [7:0] tap;
        logic [7:0] edge_tap;
        logic       done;
        logic       err;
        int         gap;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_mark = 0;
    int   last_cyc = 0;
    int   clear_cnt = 0;
    int   evt_idx = 0;
    int   model_tap = 0;
    logic toggle = 1'b0;
    int   unstable_below = 0;
    int   edge_at = 1000;
    int   oor_at = 1000;
    int   early_at = 1000;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    initial forever #5 FAB_CLK = ~FAB_CLK;
    initial forever begin
        @(posedge FAB_CLK);
        cyc = cyc + 1;
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached with %0d events pending", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    // Delay-line / lane model: tracks the tap from LOAD/MOVE and presents the pattern for that tap.
    initial forever begin
        @(negedge FAB_CLK);
        if (DELAY_LINE_LOAD) model_tap = 0;
        else if (DELAY_LINE_MOVE) model_tap = DELAY_LINE_DIRECTION ? model_tap + 1 : model_tap - 1;
        toggle = ~toggle;
        if (model_tap < unstable_below) RX_DATA = toggle ? 8'hAA : 8'h55;
        else if (model_tap >= edge_at)  RX_DATA = 8'hAA;
        else                            RX_DATA = 8'h55;
        DELAY_LINE_OUT_OF_RANGE = (model_tap >= oor_at);
        EYE_MONITOR_EARLY       = (model_tap == early_at);
    end

    task automatic check_event(input evt_t act);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got kind=%0d tap=%0d edge=%0d done=%0b err=%0b, required no event",
                     act.kind, act.tap, act.edge_tap, act.done, act.err);
        end else begin
            e = exp_q.pop_front();
            if (act.kind !== e.kind || act.dir !== e.dir || act.tap !== e.tap || act.edge_tap !== e.edge_tap ||
                act.done !== e.done || act.err !== e.err || act.gap !== e.gap) begin
                errors++;
                $display("[TB] FAIL event%0d: got kind=%0d dir=%0b tap=%0d edge=%0d done=%0b err=%0b gap=%0d, required kind=%0d dir=%0b tap=%0d edge=%0d done=%0b err=%0b gap=%0d",
                         evt_idx, act.kind, act.dir, act.tap, act.edge_tap, act.done, act.err, act.gap,
                         e.kind, e.dir, e.tap, e.edge_tap, e.done, e.err, e.gap);
            end
        end
        evt_idx++;
    endtask

    // Monitor: turns DUT strobes and status rises into events for the scoreboard.
    initial forever begin
        evt_t act;
        int   npulse;
        @(negedge FAB_CLK);
        if (ARST_N) begin
            npulse = int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS);
            if (npulse > 0) begin
                checks++;
                if (npulse > 1) begin
                    errors++;
                    $display("[TB] FAIL pulse_exclusive: got %0d strobes in cycle %0d, required at most 1", npulse, cyc);
                end
            end
            if (EYE_MONITOR_CLEAR_FLAGS) clear_cnt++;
            act.dir = 1'b0;
            act.tap = TAP_COUNT;
            act.edge_tap = EDGE_TAP;
            act.done = TRAIN_DONE;
            act.err = TRAIN_ERR;
            if (DELAY_LINE_LOAD) begin
                act.kind = 0;
                act.gap  = cyc - start_mark;
                last_cyc = cyc;
                check_event(act);
            end
            if (DELAY_LINE_MOVE) begin
                act.kind = 1;
                act.dir  = DELAY_LINE_DIRECTION;
                act.gap  = cyc - last_cyc;
                last_cyc = cyc;
                check_event(act);
            end
            if ((TRAIN_DONE && !prev_done) || (TRAIN_ERR && !prev_err)) begin
                act.kind = 2;
                act.dir  = 1'b0;
                act.gap  = cyc - last_cyc;
                last_cyc = cyc;
                check_event(act);
            end
        end
        prev_done = TRAIN_DONE;
        prev_err  = TRAIN_ERR;
    end

    task automatic push_evt(input int kind, input logic dir, input int tap, input int edge_tap,
                            input logic done, input logic err, input int gap);
        evt_t e;
        e.kind = kind; e.dir = dir; e.tap = 8'(tap); e.edge_tap = 8'(edge_tap);
        e.done = done; e.err = err; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_up(input int from, input int n);
        for (int i = 0; i < n; i++) push_evt(1, 1'b1, from + i, 0, 1'b0, 1'b0, 27);
    endtask

    task automatic push_down(input int from, input int n, input int edge_tap);
        for (int i = 0; i < n; i++) push_evt(1, 1'b0, from - i, edge_tap, 1'b0, 1'b0, (i == 0) ? 27 : 17);
    endtask

    task automatic set_model(input int unstable, input int edge_tap, input int oor, input int early);
        unstable_below = unstable;
        edge_at        = edge_tap;
        oor_at         = oor;
        early_at       = early;
    endtask

    task automatic apply_stimulus();
        @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        start_mark  = cyc + 1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic reset_dut();
        ARST_N = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        ARST_N = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(negedge FAB_CLK);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %0d events still pending after %0d cycles, required 0", name, exp_q.size(), limit);
            exp_q.delete();
            reset_dut();
        end
        repeat (8) @(negedge FAB_CLK);
    endtask

    function automatic logic [31:0] out_vec();
        return {13'd0, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
                TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT, EDGE_TAP};
    endfunction

    initial begin
        int clr_base;
        int clr_req;
        #2 ARST_N = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        check_output("reset_outputs", out_vec(), 32'd0);
        ARST_N = 1'b1;
        repeat (2) @(negedge FAB_CLK);

        $display("[TB] edge at tap 40, back-off of four");
        set_model(0, 40, 1000, 1000);
        push_evt(0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        push_up(0, 40);
        push_down(40, 4, 40);
        push_evt(2, 1'b0, 36, 40, 1'b1, 1'b0, 1);
        clr_base = clear_cnt;
        apply_stimulus();
        wait_drain("edge40", 2000);
`ifdef REF_CLK_TRAIN_EYE_MON_EN
        clr_req = 41;
`else
        clr_req = 0;
`endif
        check_output("clear_pulses", 32'(clear_cnt - clr_base), 32'(clr_req));
        check_output("edge40_busy", {31'd0, TRAIN_BUSY}, 32'd0);

        $display("[TB] unstable taps 0-2, edge at tap 20");
        set_model(3, 20, 1000, 1000);
        push_evt(0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        push_up(0, 20);
        push_down(20, 4, 20);
        push_evt(2, 1'b0, 16, 20, 1'b1, 1'b0, 1);
        apply_stimulus();
        wait_drain("unstable", 1500);

        $display("[TB] no edge, search runs to the last tap");
        set_model(0, 1000, 1000, 1000);
        push_evt(0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        push_up(0, 127);
        push_evt(2, 1'b0, 127, 0, 1'b0, 1'b1, 28);
        apply_stimulus();
        wait_drain("no_edge", 5000);
        check_output("no_edge_done", {31'd0, TRAIN_DONE}, 32'd0);

        $display("[TB] out-of-range at tap 10");
        set_model(0, 1000, 10, 1000);
        push_evt(0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        push_up(0, 10);
        push_evt(2, 1'b0, 10, 0, 1'b0, 1'b1, 27);
        apply_stimulus();
        wait_drain("oor", 1000);

        $display("[TB] edge at tap 2, back-off saturates at tap 0");
        set_model(0, 2, 1000, 1000);
        push_evt(0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        push_up(0, 2);
        push_down(2, 2, 2);
        push_evt(2, 1'b0, 0, 2, 1'b1, 1'b0, 1);
        apply_stimulus();
        wait_drain("edge2", 500);

        $display("[TB] asynchronous reset during the sample window");
        set_model(0, 1000, 1000, 1000);
        push_evt(0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        apply_stimulus();
        repeat (20) @(negedge FAB_CLK);
        check_output("pre_reset_busy", {31'd0, TRAIN_BUSY}, 32'd1);
        #2 ARST_N = 1'b0;
        #1 check_output("abort_outputs", out_vec(), 32'd0);
        repeat (3) @(negedge FAB_CLK);
        ARST_N = 1'b1;
        repeat (60) @(negedge FAB_CLK);
        check_output("abort_idle", out_vec(), 32'd0);
        wait_drain("abort", 10);

        $display("[TB] eye-monitor early flag at tap 25");
        set_model(0, 1000, 1000, 25);
        push_evt(0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
`ifdef REF_CLK_TRAIN_EYE_MON_EN
        push_up(0, 25);
        push_down(25, 4, 25);
        push_evt(2, 1'b0, 21, 25, 1'b1, 1'b0, 1);
`else
        push_up(0, 127);
        push_evt(2, 1'b0, 127, 0, 1'b0, 1'b1, 28);
`endif
        apply_stimulus();
        wait_drain("eye_mon", 5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
